voice_sequencer: RTL and testbench

Time-multiplexes one shared phase2sample datapath (wave ROM lookup, mirroring and L/R crossfade) across NVOICES voices. It holds the per-voice phase accumulators and voice configuration. On each sample-rate tick it issues one ce slot per voice plus one flush slot, collects the datapath output and averages the voices into a single 8-bit mix sample. It sits between the control/config bus and the phase2sample instance and drives that instance's ce and all of its data inputs.

---
 rtl/voice_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_voice_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sequencer.sv
// Time-multiplexes one phase2sample datapath across NVOICES voices and averages them into a mix.
// Optional hard sync of voice phases on tick: define VSEQ_PHASE_SYNC_EN.
module voice_sequencer #(
    parameter int unsigned NVOICES = 8,
    parameter int unsigned PHASE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       ovr_clr,
    input  logic                       cfg_we,
    input  logic [$clog2(NVOICES)-1:0] cfg_voice,
    input  logic [1:0]                 cfg_sel,
    input  logic [15:0]                cfg_data,
`ifdef VSEQ_PHASE_SYNC_EN
    input  logic [NVOICES-1:0]         phase_sync,
`endif
    output logic                       p2s_ce,
    output logic [6:0]                 p2s_phase,
    output logic [7:0]                 p2s_wfm_l,
    output logic [7:0]                 p2s_wfm_r,
    output logic [7:0]                 p2s_factor,
    input  logic [7:0]                 p2s_sample,
    output logic [7:0]                 mix_out,
    output logic                       mix_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned VW = $clog2(NVOICES);
    localparam int unsigned SW = VW + 1;
    localparam int unsigned AW = 8 + VW;
    localparam logic [SW-1:0] LastVoice = SW'(NVOICES - 1);
    localparam logic [SW-1:0] FlushSlot = SW'(NVOICES);
    localparam logic [SW-1:0] FirstTerm = SW'(2);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;

    logic [PHASE_W-1:0] phase_q [NVOICES];
    logic [PHASE_W-1:0] phase_d [NVOICES];
    logic [PHASE_W-1:0] inc_q   [NVOICES];
    logic [PHASE_W-1:0] inc_d   [NVOICES];
    logic [7:0]         wfm_l_q [NVOICES];
    logic [7:0]         wfm_l_d [NVOICES];
    logic [7:0]         wfm_r_q [NVOICES];
    logic [7:0]         wfm_r_d [NVOICES];
    logic [7:0]         fac_q   [NVOICES];
    logic [7:0]         fac_d   [NVOICES];
    logic [NVOICES-1:0] en_q, en_d;

    logic       p2s_ce_q, p2s_ce_d;
    logic [6:0] p2s_phase_q, p2s_phase_d;
    logic [7:0] p2s_wfm_l_q, p2s_wfm_l_d;
    logic [7:0] p2s_wfm_r_q, p2s_wfm_r_d;
    logic [7:0] p2s_fac_q, p2s_fac_d;
    logic       slot_en_q, slot_en_d;
    logic       en_p1_q, en_p1_d;
    logic       en_p2_q, en_p2_d;

    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] mix_sum;
    logic [7:0]    mix_q, mix_d;
    logic [7:0]    term;
    logic          mix_valid_q, mix_valid_d;
    logic          overrun_q, overrun_d;

    logic               tick_accept;
    logic               load_voice;
    logic               load_flush;
    logic [VW-1:0]      load_idx;
    logic [PHASE_W-1:0] load_base;

    assign tick_accept = (state_q == StIdle) && tick;
    assign load_voice  = tick_accept || ((state_q == StIssue) && (slot_q < LastVoice));
    assign load_flush  = (state_q == StIssue) && (slot_q == LastVoice);
    assign load_idx    = (state_q == StIdle) ? '0 : VW'(slot_q + 1'b1);

    // Hard-synced voice 0 must issue phase 0 in the same edge the sync is taken.
    always_comb begin
        load_base = phase_q[load_idx];
`ifdef VSEQ_PHASE_SYNC_EN
        if (tick_accept && phase_sync[0]) begin
            load_base = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StIssue;
                    slot_d  = '0;
                end
            end
            StIssue: begin
                if (slot_q == FlushSlot) begin
                    state_d = StDrain;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int v = 0; v < int'(NVOICES); v++) begin
            inc_d[v]   = inc_q[v];
            wfm_l_d[v] = wfm_l_q[v];
            wfm_r_d[v] = wfm_r_q[v];
            fac_d[v]   = fac_q[v];
        end
        en_d = en_q;
        if (cfg_we) begin
            case (cfg_sel)
                2'd0: inc_d[cfg_voice] = PHASE_W'(cfg_data);
                2'd1: begin
                    wfm_l_d[cfg_voice] = cfg_data[7:0];
                    wfm_r_d[cfg_voice] = cfg_data[15:8];
                end
                2'd2: begin
                    fac_d[cfg_voice] = cfg_data[7:0];
                    en_d[cfg_voice]  = cfg_data[8];
                end
                default: ;
            endcase
        end
    end

    // The phase advances on the edge that latches its slot outputs, so a config
    // write landing during the slot cycle only affects the next frame.
    always_comb begin
        for (int v = 0; v < int'(NVOICES); v++) begin
            phase_d[v] = phase_q[v];
        end
`ifdef VSEQ_PHASE_SYNC_EN
        if (tick_accept) begin
            for (int v = 0; v < int'(NVOICES); v++) begin
                if (phase_sync[v]) begin
                    phase_d[v] = '0;
                end
            end
        end
`endif
        if (load_voice && en_q[load_idx]) begin
            phase_d[load_idx] = load_base + inc_q[load_idx];
        end
    end

    always_comb begin
        p2s_ce_d    = load_voice || load_flush;
        p2s_phase_d = '0;
        p2s_wfm_l_d = '0;
        p2s_wfm_r_d = '0;
        p2s_fac_d   = '0;
        slot_en_d   = 1'b0;
        if (load_voice) begin
            p2s_phase_d = load_base[PHASE_W-1 -: 7];
            p2s_wfm_l_d = wfm_l_q[load_idx];
            p2s_wfm_r_d = wfm_r_q[load_idx];
            p2s_fac_d   = fac_q[load_idx];
            slot_en_d   = en_q[load_idx];
        end
        en_p1_d = slot_en_q;
        en_p2_d = en_p1_q;
    end

    // en_p2_q lines up with the datapath's two-ce latency.
    assign term    = en_p2_q ? p2s_sample : 8'd128;
    assign mix_sum = acc_q + AW'(term);

    always_comb begin
        acc_d       = acc_q;
        mix_d       = mix_q;
        mix_valid_d = (state_q == StDrain);
        if (tick_accept) begin
            acc_d = '0;
        end else if ((state_q == StIssue) && (slot_q >= FirstTerm)) begin
            acc_d = mix_sum;
        end
        if (state_q == StDrain) begin
            mix_d = 8'(mix_sum >> VW);
        end
        if (tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            en_q        <= '0;
            p2s_ce_q    <= 1'b0;
            p2s_phase_q <= '0;
            p2s_wfm_l_q <= '0;
            p2s_wfm_r_q <= '0;
            p2s_fac_q   <= '0;
            slot_en_q   <= 1'b0;
            en_p1_q     <= 1'b0;
            en_p2_q     <= 1'b0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int v = 0; v < int'(NVOICES); v++) begin
                phase_q[v] <= '0;
                inc_q[v]   <= '0;
                wfm_l_q[v] <= '0;
                wfm_r_q[v] <= '0;
                fac_q[v]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            en_q        <= en_d;
            p2s_ce_q    <= p2s_ce_d;
            p2s_phase_q <= p2s_phase_d;
            p2s_wfm_l_q <= p2s_wfm_l_d;
            p2s_wfm_r_q <= p2s_wfm_r_d;
            p2s_fac_q   <= p2s_fac_d;
            slot_en_q   <= slot_en_d;
            en_p1_q     <= en_p1_d;
            en_p2_q     <= en_p2_d;
            acc_q       <= acc_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
            for (int v = 0; v < int'(NVOICES); v++) begin
                phase_q[v] <= phase_d[v];
                inc_q[v]   <= inc_d[v];
                wfm_l_q[v] <= wfm_l_d[v];
                wfm_r_q[v] <= wfm_r_d[v];
                fac_q[v]   <= fac_d[v];
            end
        end
    end

    assign p2s_ce     = p2s_ce_q;
    assign p2s_phase  = p2s_phase_q;
    assign p2s_wfm_l  = p2s_wfm_l_q;
    assign p2s_wfm_r  = p2s_wfm_r_q;
    assign p2s_factor = p2s_fac_q;
    assign mix_out    = mix_q;
    assign mix_valid  = mix_valid_q;
    assign busy       = (state_q != StIdle);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer (NVOICES=8, PHASE_W=16) with a two-ce datapath model
// whose sample is the slot's wfm_l value.
module tb_voice_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_voice = '0;
    logic [1:0]  cfg_sel = '0;
    logic [15:0] cfg_data = '0;
`ifdef VSEQ_PHASE_SYNC_EN
    logic [7:0]  phase_sync = '0;
`endif
    logic        p2s_ce;
    logic [6:0]  p2s_phase;
    logic [7:0]  p2s_wfm_l, p2s_wfm_r, p2s_factor, p2s_sample;
    logic [7:0]  mix_out;
    logic        mix_valid, busy, overrun;

    logic [7:0]  s1, s2;

    int checks = 0;
    int errors = 0;

    int ce_cnt, ce_first, ce_last, mv_cyc, mv_cnt, busy_cnt, mv_seen;
    logic [6:0] ph0;
    logic [7:0] wr0, fac0, wl8, wl9, mix_got;

    voice_sequencer #(.NVOICES(8), .PHASE_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .ovr_clr    (ovr_clr),
        .cfg_we     (cfg_we),
        .cfg_voice  (cfg_voice),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
`ifdef VSEQ_PHASE_SYNC_EN
        .phase_sync (phase_sync),
`endif
        .p2s_ce     (p2s_ce),
        .p2s_phase  (p2s_phase),
        .p2s_wfm_l  (p2s_wfm_l),
        .p2s_wfm_r  (p2s_wfm_r),
        .p2s_factor (p2s_factor),
        .p2s_sample (p2s_sample),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else if (p2s_ce) begin
            s1 <= p2s_wfm_l;
            s2 <= s1;
        end
    end
    assign p2s_sample = s2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int v, input int sel, input logic [15:0] d);
        cfg_voice = 3'(v);
        cfg_sel   = 2'(sel);
        cfg_data  = d;
        cfg_we    = 1'b1;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // Pulses tick, then observes 16 cycles; cycle c is E0+c.
    task automatic frame(input int ovr_at, input logic [7:0] sync);
        ce_cnt = 0; ce_first = -1; ce_last = -1;
        mv_cyc = -1; mv_cnt = 0; busy_cnt = 0;
        tick = 1'b1;
`ifdef VSEQ_PHASE_SYNC_EN
        phase_sync = sync;
`else
        if (sync != 8'd0) $display("note: phase_sync ignored in this build");
`endif
        @(negedge clk);
        tick = 1'b0;
`ifdef VSEQ_PHASE_SYNC_EN
        phase_sync = '0;
`endif
        for (int c = 1; c <= 16; c++) begin
            if (p2s_ce) begin
                ce_cnt++;
                if (ce_first < 0) ce_first = c;
                ce_last = c;
            end
            if (busy) busy_cnt++;
            if (mix_valid) begin
                mv_cnt++;
                mv_cyc = c;
                mix_got = mix_out;
            end
            if (c == 1) begin
                ph0  = p2s_phase;
                wr0  = p2s_wfm_r;
                fac0 = p2s_factor;
            end
            if (c == 8) wl8 = p2s_wfm_l;
            if (c == 9) wl9 = p2s_wfm_l;
            tick = (c == ovr_at);
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ce", 32'(p2s_ce), 0);
        chk("rst_phase", 32'(p2s_phase), 0);
        chk("rst_mix", 32'(mix_out), 0);
        chk("rst_mixvalid", 32'(mix_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All voices disabled: every term is the midpoint.
        frame(0, 8'd0);
        chk("idle_ce_cnt", 32'(ce_cnt), 9);
        chk("idle_ce_first", 32'(ce_first), 1);
        chk("idle_ce_last", 32'(ce_last), 9);
        chk("idle_mv_cyc", 32'(mv_cyc), 11);
        chk("idle_mv_cnt", 32'(mv_cnt), 1);
        chk("idle_mix", 32'(mix_got), 128);
        chk("idle_busy_cnt", 32'(busy_cnt), 11);
        chk("idle_flush_wfm", 32'(wl9), 0);
        chk("idle_overrun", 32'(overrun), 0);

        // Voice 0 advances by 2 phase steps per frame; its sample is wfm_l=0.
        cfg(0, 0, 16'h0400);
        cfg(0, 2, 16'h0100);
        frame(0, 8'd0);
        chk("ph_f1", 32'(ph0), 0);
        chk("ph_f1_mix", 32'(mix_got), 112);
        frame(0, 8'd0);
        chk("ph_f2", 32'(ph0), 2);
        frame(0, 8'd0);
        chk("ph_f3", 32'(ph0), 4);
`ifdef VSEQ_PHASE_SYNC_EN
        frame(0, 8'h01);
        chk("sync_ph", 32'(ph0), 0);
        frame(0, 8'd0);
        chk("sync_ph_next", 32'(ph0), 2);
`endif

        for (int v = 0; v < 8; v++) begin
            cfg(v, 1, 16'h00C8);
            cfg(v, 2, 16'h0100);
        end
        frame(0, 8'd0);
        chk("all200_mix", 32'(mix_got), 200);

        for (int v = 0; v < 4; v++) cfg(v, 1, 16'h00FF);
        for (int v = 4; v < 8; v++) cfg(v, 2, 16'h0000);
        frame(0, 8'd0);
        chk("half255_mix", 32'(mix_got), 191);

        for (int v = 0; v < 8; v++) begin
            cfg(v, 1, 16'(10 * (v + 1)));
            cfg(v, 2, 16'h0100);
        end
        cfg(0, 1, 16'h5A0A);
        cfg(0, 2, 16'h0133);
        frame(0, 8'd0);
        chk("ramp_mix", 32'(mix_got), 45);
        chk("ramp_wfm_r0", 32'(wr0), 32'h5A);
        chk("ramp_factor0", 32'(fac0), 32'h33);
        chk("ramp_wfm_l7", 32'(wl8), 80);
        chk("ramp_flush", 32'(wl9), 0);

        // Tick during ISSUE.
        frame(3, 8'd0);
        chk("ovr_mv_cyc", 32'(mv_cyc), 11);
        chk("ovr_ce_cnt", 32'(ce_cnt), 9);
        chk("ovr_mix", 32'(mix_got), 45);
        chk("ovr_set", 32'(overrun), 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);

        // Reset in cycle E0+5.
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_ce", 32'(p2s_ce), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_mix", 32'(mix_out), 0);
        chk("mid_wfm_l", 32'(p2s_wfm_l), 0);
        mv_seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (mix_valid) mv_seen++;
            @(negedge clk);
        end
        chk("mid_no_valid", 32'(mv_seen), 0);
        frame(0, 8'd0);
        chk("post_mv_cyc", 32'(mv_cyc), 11);
        chk("post_ce_cnt", 32'(ce_cnt), 9);
        chk("post_mix", 32'(mix_got), 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
